// File: rtl/uart_tx_fifo.sv
// Buffered 8N2 UART transmitter: a byte FIFO drained back-to-back by a frame engine onto TxD.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and STOP1.
module uart_tx_fifo #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int FifoDepth    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FifoDepth):0]  level,
  output logic                        overflow,
  output logic                        TxD,
  output logic                        TxD_busy,
  output logic [2:0]                  state_o
);

  localparam int Divisor = (ClkFrequency + Baud / 2) / Baud;
  localparam int AW      = $clog2(FifoDepth);
  localparam int LW      = AW + 1;
  localparam int CW      = $clog2(Divisor);

  if (Divisor < 2) begin : g_bad_divisor
    $error("uart_tx_fifo: clocks per bit (Divisor) must be at least 2");
  end
  if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of 2 and at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP1  = 3'd3,
    S_STOP2  = 3'd4
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_e;

  // Push handshake: wr_en is valid and ~full is ready; a byte transfers on a clk edge
  // where both are high. wr_en while full drops the byte and pulses overflow next cycle.
  logic [7:0]    mem_q [FifoDepth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, overflow_q;
  logic          push, pop;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end, load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign push = wr_en & ~full_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      full_q     <= (level_d == LW'(FifoDepth));
      empty_q    <= (level_d == '0);
      overflow_q <= wr_en & full_q;
    end
  end

  assign bit_end = (cnt_q == CW'(Divisor - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    pop     = 1'b0;
    txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (!empty_q) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP1;
      end
`endif
      S_STOP1: begin
        if (bit_end) state_d = S_STOP2;
      end
      S_STOP2: begin
        if (bit_end) begin
          if (!empty_q) load = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading the next byte restarts the bit timer so back-to-back frames have no gap.
    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = 3'd0;
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign TxD      = txd_q;
  assign TxD_busy = (state_q != S_IDLE) | ~empty_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit; frame layout follows UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 12;
`else
  localparam int FB = 11;
`endif
  localparam int FRAME = FB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, TxD, TxD_busy;
  logic [4:0] level;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  // line: bit k is the k-th bit on the wire in the 12-bit layout
  // (start, d0..d7, parity, stop, stop); the parity slot is skipped without parity.
  typedef struct {
    logic [7:0]  data;
    logic [11:0] line;
  } vec_t;
  vec_t vecs[7];

  uart_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .FifoDepth(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .TxD(TxD), .TxD_busy(TxD_busy), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line_bit(input logic [11:0] line, input int j);
`ifdef UART_TX_PARITY_EN
    return line[j];
`else
    return (j < 9) ? line[j] : line[j + 1];
`endif
  endfunction

  // Called on the first cycle of a start bit; every bit must hold for exactly DIV cycles.
  task automatic check_frame(input logic [11:0] line, input string tag);
    logic busy_last;
    busy_last = 1'b0;
    for (int j = 0; j < FB; j++) begin
      int bad;
      bad = 0;
      for (int k = 0; k < DIV; k++) begin
        if (TxD !== line_bit(line, j)) bad++;
        if (j == FB - 1 && k == DIV - 1) busy_last = TxD_busy;
        tick();
      end
      check($sformatf("%s bit%0d want=%0b wrong-samples", tag, j, line_bit(line, j)), bad, 0);
    end
    check({tag, " busy in last frame cycle"}, busy_last, 1);
    check({tag, " busy after frame"}, TxD_busy, 0);
    check({tag, " TxD idle after frame"}, TxD, 1);
    check({tag, " state idle after frame"}, state_o, 0);
  endtask

  // Scoreboard receiver: finds a start bit, samples mid-bit, compares against exp_q.
  task automatic rx_frame(input string tag, output int start_cyc);
    int n;
    logic [11:0] bits;
    logic [7:0] e;
    n = 0;
    bits = '0;
    while (TxD !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    start_cyc = cyc;
    check({tag, " start bit seen"}, TxD, 0);
    if (TxD !== 1'b0) return;
    for (int t = 0; t < FRAME; t++) begin
      if (t % DIV == DIV / 2) bits[t / DIV] = TxD;
      tick();
    end
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, " data"}, bits[8:1], e);
`ifdef UART_TX_PARITY_EN
    check({tag, " parity"}, bits[9], ^e);
`endif
    check({tag, " stop bits"}, {bits[FB - 1], bits[FB - 2]}, 2'b11);
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, line: 12'hCAA};
    vecs[1] = '{data: 8'hA3, line: 12'hD46};
    vecs[2] = '{data: 8'h0F, line: 12'hC1E};
    vecs[3] = '{data: 8'h00, line: 12'hC00};
    vecs[4] = '{data: 8'h01, line: 12'hE02};
    vecs[5] = '{data: 8'h80, line: 12'hF00};
    vecs[6] = '{data: 8'hFF, line: 12'hDFE};

    // reset state
    repeat (3) tick();
    check("rst TxD", TxD, 1);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    check("rst level", level, 0);
    check("rst overflow", overflow, 0);
    check("rst busy", TxD_busy, 0);
    check("rst state", state_o, 0);
    rst = 1'b1;
    repeat (2) tick();
    check("post-rst TxD", TxD, 1);

    // single-byte frames from idle
    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d(%02h)", v, vecs[v].data);
      wr_en = 1'b1;
      wr_data = vecs[v].data;
      tick();
      wr_en = 1'b0;
      check({tag, " empty after push"}, empty, 0);
      check({tag, " level after push"}, level, 1);
      check({tag, " TxD still idle"}, TxD, 1);
      tick();
      check({tag, " TxD start"}, TxD, 0);
      check({tag, " level after pop"}, level, 0);
      check({tag, " busy"}, TxD_busy, 1);
      check_frame(vecs[v].line, tag);
    end

    // two bytes on consecutive cycles: back-to-back frames
    begin
      int s1, s2;
      wr_en = 1'b1;
      wr_data = 8'hA3;
      exp_q.push_back(8'hA3);
      tick();
      wr_data = 8'h0F;
      exp_q.push_back(8'h0F);
      tick();
      wr_en = 1'b0;
      check("b2b level push+pop", level, 1);
      check("b2b first start", TxD, 0);
      rx_frame("b2b f0", s1);
      rx_frame("b2b f1", s2);
      check("b2b start spacing", s2 - s1, FRAME);
      check("b2b busy end", TxD_busy, 0);
    end

    // 17 pushes from idle plus one while full
    fork
      begin : pusher17
        for (int i = 0; i < 18; i++) begin
          wr_en = 1'b1;
          wr_data = 8'h10 + 8'(i);
          if (i < 17) exp_q.push_back(wr_data);
          tick();
          if (i == 0) check("burst level after push0", level, 1);
          if (i == 1) begin
            check("burst level after push1", level, 1);
            check("burst first popped", TxD, 0);
          end
          if (i == 15) check("burst full before 17th", full, 0);
          if (i == 16) begin
            check("burst level 16", level, 16);
            check("burst full", full, 1);
            check("burst no overflow yet", overflow, 0);
          end
          if (i == 17) begin
            check("burst overflow pulse", overflow, 1);
            check("burst level held", level, 16);
          end
        end
        wr_en = 1'b0;
        tick();
        check("burst overflow one clk", overflow, 0);
        check("burst level after drop", level, 16);
      end
      begin : rx17
        int sc;
        for (int f = 0; f < 17; f++) rx_frame($sformatf("burst f%0d", f), sc);
      end
    join
    check("burst queue drained", exp_q.size(), 0);
    check("burst busy end", TxD_busy, 0);

    // write while full on the exact edge the engine pops
    fork
      begin : pusher_pop
        for (int i = 0; i < 17; i++) begin
          wr_en = 1'b1;
          wr_data = 8'h40 + 8'(i);
          exp_q.push_back(wr_data);
          tick();
        end
        wr_en = 1'b0;
        repeat (FRAME - 16) tick();
        check("popedge level before", level, 16);
        check("popedge full before", full, 1);
        check("popedge stop bit", TxD, 1);
        wr_en = 1'b1;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        check("popedge overflow", overflow, 1);
        check("popedge level 15", level, 15);
        check("popedge not full", full, 0);
        tick();
        check("popedge overflow cleared", overflow, 0);
        check("popedge level stays", level, 15);
      end
      begin : rx_pop
        int sc;
        for (int f = 0; f < 17; f++) rx_frame($sformatf("popedge f%0d", f), sc);
      end
    join
    check("popedge queue drained", exp_q.size(), 0);

    // asynchronous reset during data bit 4
    begin
      int bad;
      wr_en = 1'b1;
      wr_data = 8'h00;
      tick();
      wr_data = 8'h33;
      tick();
      wr_en = 1'b0;
      repeat (52) tick();
      check("arst TxD low in d4", TxD, 0);
      check("arst level before", level, 1);
      #2 rst = 1'b0;
      #1;
      check("arst TxD high async", TxD, 1);
      check("arst level", level, 0);
      check("arst empty", empty, 1);
      check("arst full", full, 0);
      check("arst busy", TxD_busy, 0);
      check("arst state", state_o, 0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (TxD !== 1'b1 || TxD_busy !== 1'b0) bad++;
      end
      check("arst stays idle (bad cycles)", bad, 0);
      check("arst final TxD", TxD, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
